// File: rtl/ps_head_inserter.sv
// Prepends a parallel header of 1..LENGTH words to each payload packet.
// Output is a 2-entry skid buffer, so i_rdy never depends combinationally on o_rdy.
module ps_head_inserter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LENGTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LENGTH-1:0][WIDTH-1:0]  i_hdr,
  input  logic [$clog2(LENGTH)-1:0]     i_len,
  input  logic [WIDTH-1:0]              i_dat,
  input  logic                          i_val,
  input  logic                          i_eop,
  output logic                          i_rdy,
  output logic [WIDTH-1:0]              o_dat,
  output logic                          o_val,
  output logic                          o_eop,
  input  logic                          o_rdy
);

  localparam int unsigned CntW = $clog2(LENGTH);
  localparam logic [CntW-1:0] LenMax = CntW'(LENGTH - 1);

  typedef enum logic {StHead, StBody} state_e;

  state_e                       state_q, state_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [CntW-1:0]              len_q, len_d;
  logic [CntW-1:0]              len_clamp, len_cur;
  logic [LENGTH-1:0][WIDTH-1:0] hdr_q, hdr_d;

  logic             src_val, src_eop, src_xfer, s_rdy;
  logic [WIDTH-1:0] src_dat;

  logic [WIDTH-1:0] skid_dat_q;
  logic             skid_eop_q, skid_val_q;

  assign len_clamp = (i_len > LenMax) ? LenMax : i_len;
  // The first header word is compared against the live length; later ones use the latched copy.
  assign len_cur   = (cnt_q == '0) ? len_clamp : len_q;
  assign s_rdy     = ~skid_val_q;
  assign src_xfer  = src_val & s_rdy;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHead;
      cnt_q   <= '0;
      len_q   <= '0;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      hdr_q   <= hdr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    hdr_d   = hdr_q;
    case (state_q)
      StHead: begin
        if (src_xfer) begin
          if (cnt_q == '0) begin
            hdr_d = i_hdr;
            len_d = len_clamp;
          end
          if (cnt_q == len_cur) begin
            cnt_d   = '0;
            state_d = StBody;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StBody: begin
        if (src_xfer && i_eop) begin
          cnt_d   = '0;
          state_d = StHead;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StHead;
      end
    endcase
  end

  // Output logic: internal source mux feeding the skid buffer
  always_comb begin
    src_val = i_val;
    src_dat = i_dat;
    src_eop = 1'b0;
    i_rdy   = 1'b0;
    case (state_q)
      StHead: begin
        src_dat = (cnt_q == '0) ? i_hdr[0] : hdr_q[cnt_q];
      end
      StBody: begin
        src_eop = i_eop;
        i_rdy   = s_rdy;
      end
      default: begin
        src_val = 1'b0;
      end
    endcase
  end

  // Output register plus one skid entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_dat      <= '0;
      o_val      <= 1'b0;
      o_eop      <= 1'b0;
      skid_dat_q <= '0;
      skid_eop_q <= 1'b0;
      skid_val_q <= 1'b0;
    end else if (skid_val_q) begin
      if (o_val && o_rdy) begin
        o_dat      <= skid_dat_q;
        o_eop      <= skid_eop_q;
        o_val      <= 1'b1;
        skid_val_q <= 1'b0;
      end
    end else if (src_xfer) begin
      if (!o_val || o_rdy) begin
        o_dat <= src_dat;
        o_eop <= src_eop;
        o_val <= 1'b1;
      end else begin
        skid_dat_q <= src_dat;
        skid_eop_q <= src_eop;
        skid_val_q <= 1'b1;
      end
    end else if (o_val && o_rdy) begin
      o_val <= 1'b0;
    end
  end

endmodule

// File: doc/ps_head_inserter.md
PS_HEAD_INSERTER -- requirements
Module: ps_head_inserter

Interface
REQ-001 Parameter WIDTH, default 8, stream word width in bits.
REQ-002 Parameter LENGTH, default 4, maximum header length in words; LENGTH > 1 SHALL be required.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 i_hdr  input  [LENGTH-1:0][WIDTH-1:0]  parallel header; element 0 SHALL be sent first; stable while i_val is asserted for the packet's first word.
REQ-006 i_len  input  $clog2(LENGTH)  header length minus 1.
REQ-007 i_dat  input  WIDTH  payload word.
REQ-008 i_val  input  1  payload word valid.
REQ-009 i_eop  input  1  last payload word of packet.
REQ-010 i_rdy  output  1  payload word accepted when i_val & i_rdy.
REQ-011 o_dat  output  WIDTH  output word, registered.
REQ-012 o_val  output  1  output valid, registered.
REQ-013 o_eop  output  1  output end of packet, registered.
REQ-014 o_rdy  input  1  downstream ready.

Function
REQ-015 Each output packet SHALL be header words 0..L followed by every payload word of one input packet, where L = min(i_len, LENGTH-1).
REQ-016 FSM SHALL have two states: HEAD (emitting header) and BODY (forwarding payload).
REQ-017 Internal source in HEAD: src_val = i_val, src_eop = 0, i_rdy = 0; src_dat = i_hdr[0] when cnt = 0, otherwise hdr_reg[cnt].
REQ-018 Internal source in BODY: src_val = i_val, src_dat = i_dat, src_eop = i_eop, i_rdy = s_rdy.
REQ-019 On a HEAD transfer with cnt = 0, the block SHALL latch i_hdr into hdr_reg and L into len_reg.
REQ-020 An i_len value greater than LENGTH-1 SHALL be clamped to LENGTH-1.
REQ-021 A source transfer is src_val & s_rdy.
REQ-022 HEAD transfer with cnt = len_reg SHALL set cnt to 0 and move to BODY; otherwise cnt SHALL increment by 1.
REQ-023 A BODY transfer with i_eop SHALL move to HEAD with cnt = 0.
REQ-024 cnt SHALL be $clog2(LENGTH) bits wide and SHALL never exceed LENGTH-1.
REQ-025 The output stage SHALL be a 2-entry skid buffer: an output register (o_dat/o_val/o_eop) plus one skid register.
REQ-026 s_rdy SHALL equal ~skid_val (registered), so i_rdy has no combinational path from o_rdy.
REQ-027 A source transfer SHALL load the output register when it is empty or o_rdy = 1, and SHALL load the skid register otherwise.
REQ-028 When the output drains (o_val & o_rdy) and skid_val = 1, the skid contents SHALL move to the output register and skid_val SHALL clear.
REQ-029 Latency from source transfer to o_val SHALL be 1 cycle with an unstalled output.
REQ-030 Sustained throughput SHALL be 1 word/cycle with o_rdy held at 1, including HEAD-to-BODY and BODY-to-HEAD boundaries.
REQ-031 o_dat and o_eop SHALL hold stable while o_val & ~o_rdy; no word SHALL be lost or duplicated.
REQ-032 A single-word payload (i_eop on the first payload word) SHALL produce L+1 header words followed by one word with o_eop = 1.
REQ-033 The block SHALL not inspect payload contents; a zero-length payload SHALL not be possible.

Reset
REQ-034 Reset SHALL set: state = HEAD, cnt = 0, len_reg = 0, hdr_reg = 0, o_val = 0, o_dat = 0, o_eop = 0, skid_val = 0.
REQ-035 i_rdy SHALL be 0 during and immediately after reset, until the header of the first packet has been emitted.
REQ-036 Reset asserted mid-packet SHALL discard the partial packet; the next packet after release SHALL start with header word 0.

Verification
REQ-037 WIDTH=8, LENGTH=4, i_hdr={04,03,02,01}, i_len=3, payload AA,BB(eop), o_rdy=1 -> output 01,02,03,04,AA,BB with eop on BB; 6 consecutive valid cycles.
REQ-038 LENGTH=3, i_len=3 (clamped to 2), i_hdr={33,22,11}, single-word payload 55(eop) -> output 11,22,33,55(eop).
REQ-039 Random o_rdy (50%) over 200 random packets -> output matches the reference-model concatenation; i_rdy never depends combinationally on o_rdy.
REQ-040 o_rdy=0 for 5 cycles while the header is being emitted -> o_dat frozen, at most 2 words buffered, stream resumes without loss on o_rdy=1.
REQ-041 Back-to-back packets with different i_hdr/i_len -> second header begins the cycle after the first eop word is output; no gap at o_rdy=1.
REQ-042 reset pulse during BODY of packet 1 -> o_val=0 after reset; packet 2 output starts with its header word 0.
